// File: rtl/lc3b_mem_responder_pkg.sv
// lc3b_mem_responder_pkg: shared LC-3b memory types and responder FSM state encoding
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_mem_responder_lfsr8.sv
// lc3b_lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 on reset, used to draw random stall cycles
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   en    in  step enable
//   q     out current LFSR state
module lc3b_lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= 8'hA5;
        else if (en)
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};

endmodule

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: LC-3b memory-side responder with word SRAM, fixed latency and optional random stalls
//   clk             in  clock, rising edge
//   rst_n           in  asynchronous active-low reset
//   mem_read        in  read request, held until mem_resp
//   mem_write       in  write request, held until mem_resp
//   mem_byte_enable in  write byte mask, [0]=bits 7:0, [1]=bits 15:8
//   mem_address     in  byte address, bit 0 ignored, wraps modulo 2*DEPTH_WORDS
//   mem_wdata       in  write data
//   mem_rdata       out read data, updated only when a read completes
//   mem_resp        out one-cycle completion pulse
//   mem_err         out sticky flag: read and write requested together
// Define MEM_RESP_RANDOM_STALL_EN to add 0..3 LFSR-drawn wait cycles per request.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  logic [15:0]   mem_address,
    input  lc3b_word      mem_wdata,
    output lc3b_word      mem_rdata,
    output logic          mem_resp,
    output logic          mem_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 4);
    localparam logic [CW-1:0] BASE = CW'(LATENCY - 1);

    lc3b_memresp_state state, next_state;
    logic [CW-1:0]     cnt, init_cnt;
    logic [AW-1:0]     idx, addr_idx, rd_idx;
    lc3b_mem_wmask     be;
    lc3b_word          wdata;
    logic              op_read, rd_op, req;
    logic [1:0]        extra;
    logic              unused_addr;
    lc3b_word          sram [DEPTH_WORDS];

`ifdef MEM_RESP_RANDOM_STALL_EN
    logic [7:0] lfsr_q;
    logic       unused_lfsr;
    lc3b_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr_q)
    );
    assign extra       = lfsr_q[1:0];
    assign unused_lfsr = ^lfsr_q[7:2];
`else
    assign extra = 2'b00;
`endif

    assign unused_addr = ^mem_address;
    assign req         = mem_read | mem_write;
    assign addr_idx    = mem_address[AW:1];
    // the WAIT state lasts init_cnt cycles; zero means straight to RESP
    assign init_cnt    = BASE + CW'(extra);
    // the read word is loaded on the edge entering RESP, which is the capture edge when there is no WAIT
    assign rd_op       = (state == IDLE) ? mem_read : op_read;
    assign rd_idx      = (state == IDLE) ? addr_idx : idx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;

    always_comb begin
        next_state = (state == IDLE) ? (req ? ((init_cnt == '0) ? RESP : WAIT) : IDLE) :
                     (state == WAIT) ? ((cnt == CW'(1)) ? RESP : WAIT) :
                     IDLE;
    end

    always_comb begin
        mem_resp = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt       <= '0;
            op_read   <= 1'b0;
            idx       <= '0;
            be        <= '0;
            wdata     <= '0;
            mem_err   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            if (state == IDLE && req) begin
                op_read <= mem_read;
                idx     <= addr_idx;
                be      <= mem_byte_enable;
                wdata   <= mem_wdata;
                cnt     <= init_cnt;
                if (mem_read && mem_write)
                    mem_err <= 1'b1;
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (next_state == RESP && rd_op)
                mem_rdata <= sram[rd_idx];
        end

    // not reset: contents survive rst_n, and a reset before the RESP edge drops the write
    always_ff @(posedge clk)
        if (state == RESP && !op_read) begin
            if (be[0])
                sram[idx][7:0] <= wdata[7:0];
            if (be[1])
                sram[idx][15:8] <= wdata[15:8];
        end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb_lc3b_mem_responder: randomized self-checking bench against a behavioural memory/latency model
module tb_lc3b_mem_responder;

    localparam int DW  = 256;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic [15:0] mem_address = 16'h0;
    logic [15:0] mem_wdata = 16'h0;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        mem_err;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem_m [DW];
    logic [15:0] m_rdata = 16'h0;
    logic        m_err = 1'b0;
    logic [7:0]  m_lfsr;
    int          cap_extra;

    lc3b_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    // stall source reference: next bit is parity of taps 8,6,5,4
    always @(posedge clk or negedge rst_n)
        if (!rst_n)
            m_lfsr <= 8'hA5;
        else
            m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};

    function automatic int extra_now();
`ifdef MEM_RESP_RANDOM_STALL_EN
        return int'(m_lfsr[1:0]);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [15:0] addr, input logic [1:0] be,
                       input logic [15:0] wd, output logic [15:0] rdat, output int lat);
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        cap_extra       = extra_now();
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1 && !mem_resp) begin
                mem_address     = 16'($urandom);
                mem_wdata       = 16'($urandom);
                mem_byte_enable = 2'($urandom);
            end
        end while (!mem_resp && lat < 20);
        rdat      = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
    endtask

    task automatic op(input logic rd, input logic wr, input logic [15:0] addr, input logic [1:0] be,
                      input logic [15:0] wd, input string tag, output logic [15:0] rdat);
        int lat;
        int i;
        txn(rd, wr, addr, be, wd, rdat, lat);
        chk({tag, "_lat"}, lat, LAT + cap_extra);
`ifdef MEM_RESP_RANDOM_STALL_EN
        chk({tag, "_latrange"}, 32'(lat >= 3 && lat <= 6), 1);
`endif
        i = (int'(addr) % (2 * DW)) / 2;
        if (rd) begin
            m_rdata = mem_m[i];
            if (wr)
                m_err = 1'b1;
        end else begin
            if (be[0]) mem_m[i][7:0]  = wd[7:0];
            if (be[1]) mem_m[i][15:8] = wd[15:8];
        end
        chk({tag, "_rdata"}, rdat, m_rdata);
        chk({tag, "_err"}, mem_err, m_err);
    endtask

    initial begin
        logic [15:0] r;
        int n;
        #2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp", mem_resp, 0);
        chk("rst_rdata", mem_rdata, 16'h0);
        chk("rst_err", mem_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < DW; a++)
            op(0, 1, 16'(2 * a), 2'b11, 16'($urandom), "init", r);

        op(0, 1, 16'h0010, 2'b11, 16'hBEEF, "t1_wr", r);
        op(1, 0, 16'h0010, 2'b00, 16'h0, "t1_rd", r);
        chk("t1_beef", r, 16'hBEEF);

        op(0, 1, 16'h0020, 2'b11, 16'h1234, "t2_pre", r);
        op(0, 1, 16'h0020, 2'b10, 16'hAB00, "t2_hi", r);
        op(1, 0, 16'h0020, 2'b00, 16'h0, "t2_rd1", r);
        chk("t2_ab34", r, 16'hAB34);
        op(0, 1, 16'h0021, 2'b01, 16'h00CD, "t2_lo", r);
        op(1, 0, 16'h0020, 2'b11, 16'h0, "t2_rd2", r);
        chk("t2_abcd", r, 16'hABCD);

        op(0, 1, 16'h0202, 2'b11, 16'h7777, "t4_wr", r);
        op(1, 0, 16'h0002, 2'b00, 16'h0, "t4_rd", r);
        chk("t4_wrap", r, 16'h7777);
        op(0, 1, 16'h0002, 2'b00, 16'hFFFF, "t4_be0", r);
        op(1, 0, 16'h0003, 2'b00, 16'h0, "t4_rd0", r);
        chk("t4_be0_keep", r, 16'h7777);

        op(0, 1, 16'h0030, 2'b11, 16'h0F0F, "t3_pre", r);
        @(negedge clk);
        mem_write = 1'b1; mem_address = 16'h0030; mem_byte_enable = 2'b11; mem_wdata = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        mem_write = 1'b0;
        #1;
        chk("t3_resp_async", mem_resp, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t3_resp_in_rst", mem_resp, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t3_rdata_zero", mem_rdata, 16'h0);
        m_rdata = 16'h0;
        m_err = 1'b0;
        op(1, 0, 16'h0030, 2'b00, 16'h0, "t3_rd", r);
        chk("t3_old", r, 16'h0F0F);

        op(1, 1, 16'h0010, 2'b11, 16'h1111, "t5_both", r);
        chk("t5_mem_keep", mem_m[8], 16'hBEEF);
        @(negedge clk);
        mem_read = 1'b1; mem_address = 16'h0020;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) cap_extra = extra_now();
        end while (!mem_resp && n < 20);
        chk("t5_first_resp", mem_resp, 1);
        chk("t5_first_rd", mem_rdata, 16'hABCD);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) cap_extra = extra_now();
        end while (!mem_resp && n < 20);
        chk("t5_spacing", n, 1 + LAT + cap_extra);
        chk("t5_second_rd", mem_rdata, 16'hABCD);
        mem_read = 1'b0;
        @(posedge clk);
        m_rdata = 16'hABCD;
        chk("t5_err_sticky", mem_err, 1);

        for (int k = 0; k < 100; k++) begin
            if ($urandom_range(0, 1) == 1)
                op(1, 0, 16'($urandom), 2'($urandom), 16'($urandom), "rnd_rd", r);
            else
                op(0, 1, 16'($urandom), 2'($urandom), 16'($urandom), "rnd_wr", r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
